// File: rtl/fphub_div_pkg.sv
// fphub_div_pkg: shared types, special-case codes and constant builders for the FPHUB divider
package fphub_div_pkg;
    localparam int FP_E = 8;
    localparam int FP_M = 23;
    typedef logic [FP_E+FP_M:0] fphub_t;
    localparam logic [2:0] CASE_NONE   = 3'd0;
    localparam logic [2:0] CASE_X_INF  = 3'd1;
    localparam logic [2:0] CASE_X_ZERO = 3'd2;
    localparam logic [2:0] CASE_Y_ZERO = 3'd3;
    localparam logic [2:0] CASE_Y_INF  = 3'd4;
    localparam logic [2:0] CASE_Y_ONE  = 3'd5;
    localparam logic [2:0] CASE_ONE_N  = 3'd6;
    function automatic fphub_t inf_val(input logic sign);
        return {sign, {(FP_E+FP_M){1'b1}}};
    endfunction
    function automatic fphub_t zero_val(input logic sign);
        return {sign, {(FP_E+FP_M){1'b0}}};
    endfunction
endpackage

// File: rtl/fphub_div_issue_ctrl_detector.sv
// special_cases_detector: classifies a dividend/divisor pair into a prioritised special-case code
module special_cases_detector
    import fphub_div_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 23,
    parameter int CW = 3
) (
    input  logic [E+M:0] x,
    input  logic [E+M:0] y,
    output logic [CW-1:0] code,
    output logic         x_one
);
    localparam logic [E+M-1:0] ONE_MAG = {1'b1, {(E+M-1){1'b0}}};
    logic x_inf, x_zero, y_inf, y_zero, y_one;
    always_comb begin
        x_inf  = &x[E+M-1:0];
        x_zero = ~|x[E+M-1:0];
        y_inf  = &y[E+M-1:0];
        y_zero = ~|y[E+M-1:0];
        y_one  = y[E+M-1:0] == ONE_MAG;
        x_one  = x[E+M-1:0] == ONE_MAG;
        code   = x_inf  ? CW'(CASE_X_INF)  :
                 x_zero ? CW'(CASE_X_ZERO) :
                 y_zero ? CW'(CASE_Y_ZERO) :
                 y_inf  ? CW'(CASE_Y_INF)  :
                 y_one  ? CW'(CASE_Y_ONE)  :
                 x_one  ? CW'(CASE_ONE_N)  : CW'(CASE_NONE);
    end
endmodule

// File: rtl/fphub_div_issue_ctrl.sv
// fphub_div_issue_ctrl: accepts operand pairs, bypasses special quotients, launches the rest into the divider core
module fphub_div_issue_ctrl
    import fphub_div_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8,
    parameter int special_case = 7
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] in_x,
    input  logic [E+M:0] in_y,
    output logic         core_start,
    output logic [E+M:0] core_x,
    output logic [E+M:0] core_y,
    output logic         core_x_one,
    input  logic         core_done,
    input  logic [E+M:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] out_data,
    output logic         out_special,
    output logic         spurious_done
);
    localparam int CW = $clog2(special_case);
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
    state_t state;
    logic [CW-1:0] code;
    logic x_one, accept, bypass, s;
    logic [E+M:0] bypass_val;
    special_cases_detector #(.E(E), .M(M), .CW(CW)) u_det (
        .x(in_x), .y(in_y), .code(code), .x_one(x_one)
    );
    always_comb begin
        in_ready   = state == IDLE || (state == OUT && out_ready);
        out_valid  = state == OUT;
        accept     = in_valid && in_ready;
        s          = in_x[E+M] ^ in_y[E+M];
        bypass     = code != CW'(CASE_NONE) && code != CW'(CASE_ONE_N);
        bypass_val = (code == CW'(CASE_X_INF) || code == CW'(CASE_Y_ZERO)) ? inf_val(s) :
                     (code == CW'(CASE_Y_ONE)) ? {s, in_x[E+M-1:0]} : zero_val(s);
    end
    always_ff @(posedge clk) begin
        if (rst_l) begin
            state         <= IDLE;
            core_start    <= 1'b0;
            core_x        <= '0;
            core_y        <= '0;
            core_x_one    <= 1'b0;
            out_data      <= '0;
            out_special   <= 1'b0;
            spurious_done <= 1'b0;
        end else begin
            core_start <= 1'b0;
            if (core_done && state != WAIT) spurious_done <= 1'b1;
            if (state == WAIT) begin
                if (core_done) begin
                    out_data    <= core_result;
                    out_special <= 1'b0;
                    state       <= OUT;
                end
            end else if (accept) begin
                // an accept in OUT also retires the current result, so both paths start fresh
                if (bypass) begin
                    out_data    <= bypass_val;
                    out_special <= 1'b1;
                    state       <= OUT;
                end else begin
                    core_x     <= in_x;
                    core_y     <= in_y;
                    core_x_one <= x_one;
                    core_start <= 1'b1;
                    state      <= WAIT;
                end
            end else if (state == OUT && out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fphub_div_issue_ctrl.sv
// tb_fphub_div_issue_ctrl: directed checks of bypass, core launch, backpressure and reset-abandon behaviour
module tb_fphub_div_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_l, in_valid, in_ready, core_start, core_x_one, core_done;
    logic        out_valid, out_ready, out_special, spurious_done;
    logic [31:0] in_x, in_y, core_x, core_y, core_result, out_data;
    int tests = 0;
    int fails = 0;
    fphub_div_issue_ctrl #(.M(23), .E(8), .special_case(7)) dut (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .core_start(core_start), .core_x(core_x),
        .core_y(core_y), .core_x_one(core_x_one), .core_done(core_done),
        .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_special(out_special), .spurious_done(spurious_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    task automatic bypass_case(input string tag, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] exp);
        push(x, y);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_special"}, 32'(out_special), 32'd1);
        chk({tag, "_nostart"}, 32'(core_start), 32'd0);
        @(negedge clk);
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask
    initial begin
        rst_l = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
        core_done = 1'b0; core_result = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_special", 32'(out_special), 32'd0);
        chk("rst_core_x", core_x, 32'd0);
        chk("rst_core_x_one", 32'(core_x_one), 32'd0);
        chk("rst_spurious", 32'(spurious_done), 32'd0);
        rst_l = 1'b0;
        @(negedge clk);
        bypass_case("inf_div_0", 32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF);
        bypass_case("nzero_div_0", 32'h80000000, 32'h00000000, 32'h80000000);
        bypass_case("x_div_nzero", 32'h41200000, 32'h80000000, 32'hFFFFFFFF);
        bypass_case("x_div_ninf", 32'h3F800000, 32'hFFFFFFFF, 32'h80000000);
        out_ready = 1'b0;
        push(32'h12345678, 32'hC0000000);
        chk("neg1_special", 32'(out_special), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'h92345678);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 32'h7FFFFFFF; in_y = 32'h00000000;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", out_data, 32'h7FFFFFFF);
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 32'd0);
        push(32'h41200000, 32'h40A00000);
        chk("core_start", 32'(core_start), 32'd1);
        chk("core_x", core_x, 32'h41200000);
        chk("core_y", core_y, 32'h40A00000);
        chk("core_x_one0", 32'(core_x_one), 32'd0);
        chk("core_wait_valid", 32'(out_valid), 32'd0);
        chk("core_wait_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("core_start_pulse", 32'(core_start), 32'd0);
        repeat (4) @(negedge clk);
        chk("core_hold_x", core_x, 32'h41200000);
        core_done = 1'b1; core_result = 32'h3F000001;
        @(negedge clk);
        core_done = 1'b0;
        chk("core_valid", 32'(out_valid), 32'd1);
        chk("core_data", out_data, 32'h3F000001);
        chk("core_special", 32'(out_special), 32'd0);
        chk("core_no_spurious", 32'(spurious_done), 32'd0);
        @(negedge clk);
        push(32'h40000000, 32'h41200000);
        chk("xone_start", 32'(core_start), 32'd1);
        chk("xone_hint", 32'(core_x_one), 32'd1);
        core_done = 1'b1; core_result = 32'h12345678;
        @(negedge clk);
        core_done = 1'b0;
        chk("xone_valid", 32'(out_valid), 32'd1);
        chk("xone_data", out_data, 32'h12345678);
        chk("xone_special", 32'(out_special), 32'd0);
        @(negedge clk);
        push(32'h41200000, 32'h40A00000);
        chk("abort_start", 32'(core_start), 32'd1);
        rst_l = 1'b1;
        @(negedge clk);
        rst_l = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_spurious0", 32'(spurious_done), 32'd0);
        core_done = 1'b1; core_result = 32'h3F000001;
        @(negedge clk);
        core_done = 1'b0;
        chk("abort_spurious1", 32'(spurious_done), 32'd1);
        chk("abort_no_valid", 32'(out_valid), 32'd0);
        chk("abort_data", out_data, 32'd0);
        @(negedge clk);
        chk("spurious_sticky", 32'(spurious_done), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
